// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 4-bit restoring divider.
package div_pkg;

  localparam int WIDTH = 4;
  localparam int ITERS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift {R,A} left, trial-subtract M, restore on borrow.
module div_restoring_step
  import div_pkg::*;
(
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] a_next
);

  // The shift is carried one bit wider so the trial subtract sees the whole shifted R.
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    r_sh   = {r, a[WIDTH-1]};
    diff   = r_sh - {2'b00, m};
    r_next = diff[WIDTH:0];
    a_next = {a[WIDTH-2:0], 1'b1};
    if (diff[WIDTH+1]) begin
      r_next = r_sh[WIDTH:0];
      a_next = {a[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_4bit_restoring.sv
// Sequential 4-bit unsigned restoring divider, one iteration per clock, launched by a start rising edge.
module div_4bit_restoring
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] operA,
  input  logic [3:0] operB,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic [1:0] state
);

  div_state_t       cur_state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   r;
  logic [2:0]       count;
  logic             start_q;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] a_next;

  div_restoring_step u_step (
    .r      (r),
    .a      (a),
    .m      (m),
    .r_next (r_next),
    .a_next (a_next)
  );

  assign state = cur_state;

  // Handshake: a launch needs start=1 with start_q=0 while IDLE; edges seen while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      a         <= '0;
      m         <= '0;
      r         <= '0;
      count     <= '0;
      start_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      start_q <= start;
      case (cur_state)
        IDLE: begin
          if (start && !start_q) begin
            a         <= operA;
            m         <= operB;
            r         <= '0;
            count     <= '0;
            cur_state <= CALC;
          end
        end
        CALC: begin
          r     <= r_next;
          a     <= a_next;
          count <= count + 3'd1;
          if (count == 3'(ITERS - 1)) cur_state <= DONE;
        end
        DONE: begin
          quotient  <= a;
          remainder <= r[WIDTH-1:0];
          cur_state <= IDLE;
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_4bit_restoring.sv
// Self-checking bench for div_4bit_restoring: directed table, corner sequences, exhaustive and random sweeps.
module tb_div_4bit_restoring;
  import div_pkg::*;

  // clock / reset
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] operA;
  logic [3:0] operB;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic [1:0] state;

  div_4bit_restoring dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operA     (operA),
    .operB     (operB),
    .quotient  (quotient),
    .remainder (remainder),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int         tests;
  int         fails;
  logic [7:0] exp_q[$];
  logic [3:0] cur_q;
  logic [3:0] cur_r;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t tbl[7];

  // Reference: plain integer division; divide by zero gives all-ones quotient and the dividend back.
  function automatic logic [7:0] model(input int ua, input int ub);
    int q;
    int r;
    if (ub == 0) begin
      q = 15;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {q[3:0], r[3:0]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with a one-cycle start pulse; returns just after the launch edge.
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    operA = a;
    operB = b;
    start = 1'b1;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
  endtask

  // Outputs must hold through edges k+1..k+4 and carry the new result after edge k+5.
  task automatic finish_op(input string name);
    logic [7:0] e;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({name, "_hold"}, {quotient, remainder}, {cur_q, cur_r});
    end
    tick();
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %h expected <none queued>", name, {quotient, remainder});
    end else begin
      e = exp_q.pop_front();
      check(name, {quotient, remainder}, e);
      cur_q = e[7:4];
      cur_r = e[3:0];
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cur_q = 4'h0;
    cur_r = 4'h0;
    rst   = 1'b1;
    start = 1'b0;
    operA = 4'h0;
    operB = 4'h0;

    tbl[0] = '{"t15_1",  4'd15, 4'd1,  4'd15, 4'd0};
    tbl[1] = '{"t13_4",  4'd13, 4'd4,  4'd3,  4'd1};
    tbl[2] = '{"t15_15", 4'd15, 4'd15, 4'd1,  4'd0};
    tbl[3] = '{"t0_7",   4'd0,  4'd7,  4'd0,  4'd0};
    tbl[4] = '{"t2_9",   4'd2,  4'd9,  4'd0,  4'd2};
    tbl[5] = '{"t14_3",  4'd14, 4'd3,  4'd4,  4'd2};
    tbl[6] = '{"t9_0",   4'd9,  4'd0,  4'd15, 4'd9};

    // Reset state
    tick();
    tick();
    check("reset_out", {quotient, remainder}, 8'h00);
    check("reset_state", {6'd0, state}, {6'd0, IDLE});
    rst = 1'b0;
    tick();

    // start held high for 10 cycles: exactly one launch
    operA = 4'd4;
    operB = 4'd2;
    start = 1'b1;
    exp_q.push_back(8'h20);
    tick();
    finish_op("held_4_2");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_single_launch", {6'd0, state}, {6'd0, IDLE});
    end
    start = 1'b0;
    tick();
    tick();

    // operA < operB; outputs stay 2/0 until the update edge
    launch(4'd3, 4'd5, 8'h03);
    finish_op("t3_5");
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      launch(tbl[i].a, tbl[i].b, {tbl[i].q, tbl[i].r});
      finish_op(tbl[i].name);
      tick();
    end

    // Async reset mid-CALC discards the operation in flight
    launch(4'd13, 4'd4, 8'h31);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_out", {quotient, remainder}, 8'h00);
    check("async_rst_state", {6'd0, state}, {6'd0, IDLE});
    exp_q.delete();
    cur_q = 4'h0;
    cur_r = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("async_rst_no_update", {quotient, remainder}, 8'h00);
    launch(4'd13, 4'd4, 8'h31);
    finish_op("relaunch_13_4");
    tick();

    // Operand change and retrigger while busy
    launch(4'd11, 4'd3, 8'h32);
    tick();
    operA = 4'd14;
    operB = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("busy_hold", {quotient, remainder}, {cur_q, cur_r});
    tick();
    check("busy_result", {quotient, remainder}, 8'h32);
    exp_q.delete();
    cur_q = 4'd3;
    cur_r = 4'd2;
    for (int i = 0; i < 3; i++) tick();
    check("busy_retrigger_ignored", {4'd0, state, quotient, remainder},
          {4'd0, IDLE, 4'd3, 4'd2});

    // Exhaustive sweep against the reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        launch(4'(ia), 4'(ib), model(ia, ib));
        finish_op("exhaustive");
        tick();
      end
    end

    // Random operands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      launch(4'(ra), 4'(rb), model(ra, rb));
      finish_op("random");
      repeat ($urandom_range(3, 1)) tick();
    end

    // start already high when reset is released counts as a rising edge
    rst   = 1'b1;
    start = 1'b1;
    operA = 4'd7;
    operB = 4'd2;
    tick();
    tick();
    cur_q = 4'h0;
    cur_r = 4'h0;
    rst   = 1'b0;
    exp_q.push_back(8'h31);
    tick();
    start = 1'b0;
    finish_op("start_at_reset_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
